alu_arb: RTL and testbench

Two-requester arbiter that time-shares one combinational 32-bit ALU between independent clients, such as the execute stage and an address/branch-compare unit. Each cycle it grants at most one request and muxes that request's operands and control code onto the ALU. It captures the ALU's `y`/`zero`/`less` into a per-requester result register, and returns the result through a valid/ready handshake with backpressure.

---
 rtl/alu_arb.sv | 118 +++++++++++
 tb/tb_alu_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arb.sv
// Two-requester arbiter sharing one combinational ALU; fixed priority, or round-robin with ALU_ARB_RR_EN.
// Latency: granted in cycle N, result and rvalid visible in cycle N+1; one ALU op per cycle in aggregate.
// Backpressure: a full result slot blocks its requester's grant unless rready drains it in the same cycle.
module alu_arb #(
    parameter int DW = 32,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic [DW-1:0] r0_a,
    input  logic [DW-1:0] r0_b,
    input  logic [CW-1:0] r0_ctr,
    output logic          r0_rvalid,
    input  logic          r0_rready,
    output logic [DW-1:0] r0_y,
    output logic          r0_zero,
    output logic          r0_less,

    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic [DW-1:0] r1_a,
    input  logic [DW-1:0] r1_b,
    input  logic [CW-1:0] r1_ctr,
    output logic          r1_rvalid,
    input  logic          r1_rready,
    output logic [DW-1:0] r1_y,
    output logic          r1_zero,
    output logic          r1_less,

    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [CW-1:0] alu_ctr,
    input  logic [DW-1:0] alu_y,
    input  logic          alu_zero,
    input  logic          alu_less
);

    logic elig0;
    logic elig1;
    logic pick0;
    logic last_grant;

    // Requests seen while reset is asserted are never granted.
    assign elig0 = !rst && r0_valid && (!r0_rvalid || r0_rready);
    assign elig1 = !rst && r1_valid && (!r1_rvalid || r1_rready);

`ifdef ALU_ARB_RR_EN
    assign pick0 = last_grant;
`else
    // Fixed priority: last_grant is still tracked so both builds share the same state.
    assign pick0 = last_grant | 1'b1;
`endif

    assign r0_ready = elig0 && (!elig1 || pick0);
    assign r1_ready = elig1 && !r0_ready;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ctr = '0;
        if (r0_ready) begin
            alu_a   = r0_a;
            alu_b   = r0_b;
            alu_ctr = r0_ctr;
        end else if (r1_ready) begin
            alu_a   = r1_a;
            alu_b   = r1_b;
            alu_ctr = r1_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (r0_ready) begin
            last_grant <= 1'b0;
        end else if (r1_ready) begin
            last_grant <= 1'b1;
        end
    end

    // A grant wins over a drain, so a same-cycle drain+refill keeps rvalid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_rvalid <= 1'b0;
            r0_y      <= '0;
            r0_zero   <= 1'b0;
            r0_less   <= 1'b0;
        end else if (r0_ready) begin
            r0_rvalid <= 1'b1;
            r0_y      <= alu_y;
            r0_zero   <= alu_zero;
            r0_less   <= alu_less;
        end else if (r0_rvalid && r0_rready) begin
            r0_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_rvalid <= 1'b0;
            r1_y      <= '0;
            r1_zero   <= 1'b0;
            r1_less   <= 1'b0;
        end else if (r1_ready) begin
            r1_rvalid <= 1'b1;
            r1_y      <= alu_y;
            r1_zero   <= alu_zero;
            r1_less   <= alu_less;
        end else if (r1_rvalid && r1_rready) begin
            r1_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: directed vector table, reset-mid-op sequence and randomized traffic vs a reference model.
// The ALU itself is modelled here; expectations follow the build's arbitration policy (ALU_ARB_RR_EN).
module tb_alu_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid, r0_rready, r1_rready;
    logic        r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [31:0] r0_a, r0_b, r1_a, r1_b, r0_y, r1_y;
    logic [3:0]  r0_ctr, r1_ctr;
    logic        r0_zero, r1_zero, r0_less, r1_less;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_ctr;
    logic        alu_zero, alu_less;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b1000;

    always #5 clk = ~clk;

    alu_arb #(.DW(32), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_ctr(r0_ctr),
        .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_y(r0_y), .r0_zero(r0_zero), .r0_less(r0_less),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_ctr(r1_ctr),
        .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_y(r1_y), .r1_zero(r1_zero), .r1_less(r1_less),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .alu_y(alu_y), .alu_zero(alu_zero), .alu_less(alu_less)
    );

    function automatic logic [31:0] f_y(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (c[2:0])
            3'b000:  return c[3] ? a - b : a + b;
            3'b001:  return a | b;
            3'b010:  return {31'd0, $signed(a) < $signed(b)};
            3'b011:  return {31'd0, a < b};
            3'b100:  return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic f_less(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        return c[0] ? (a < b) : ($signed(a) < $signed(b));
    endfunction

    // External ALU the arbiter drives.
    always_comb begin
        alu_y    = f_y(alu_a, alu_b, alu_ctr);
        alu_zero = (f_y(alu_a, alu_b, alu_ctr) == 32'd0);
        alu_less = f_less(alu_a, alu_b, alu_ctr);
    end

    // Reference model state
    bit          m_rv[2];
    logic [31:0] m_y[2];
    bit          m_z[2];
    bit          m_l[2];
    bit          m_last;
    bit          m_g[2];
    bit          act_g[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 1'b0; m_y[i] = '0; m_z[i] = 1'b0; m_l[i] = 1'b0; m_g[i] = 1'b0;
        end
        m_last = 1'b1;
    endtask

    // One clock: check combinational and registered outputs mid-cycle, then advance the model.
    task automatic cyc(input bit r);
        bit e0, e1, pick0;
        logic [31:0] ea, eb;
        logic [3:0]  ec;
        rst = r;
        @(negedge clk);
        e0 = !r && r0_valid && (!m_rv[0] || r0_rready);
        e1 = !r && r1_valid && (!m_rv[1] || r1_rready);
`ifdef ALU_ARB_RR_EN
        pick0 = (m_last != 1'b0);
`else
        pick0 = 1'b1;
`endif
        m_g[0] = e0 && (!e1 || pick0);
        m_g[1] = e1 && !m_g[0];
        ea = m_g[0] ? r0_a : (m_g[1] ? r1_a : 32'd0);
        eb = m_g[0] ? r0_b : (m_g[1] ? r1_b : 32'd0);
        ec = m_g[0] ? r0_ctr : (m_g[1] ? r1_ctr : 4'd0);
        act_g[0] = r0_ready;
        act_g[1] = r1_ready;
        chk("r0_ready", {31'd0, r0_ready}, {31'd0, m_g[0]});
        chk("r1_ready", {31'd0, r1_ready}, {31'd0, m_g[1]});
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_ctr", {28'd0, alu_ctr}, {28'd0, ec});
        chk("r0_rvalid", {31'd0, r0_rvalid}, {31'd0, m_rv[0]});
        chk("r1_rvalid", {31'd0, r1_rvalid}, {31'd0, m_rv[1]});
        chk("r0_y", r0_y, m_y[0]);
        chk("r1_y", r1_y, m_y[1]);
        chk("r0_flags", {30'd0, r0_zero, r0_less}, {30'd0, m_z[0], m_l[0]});
        chk("r1_flags", {30'd0, r1_zero, r1_less}, {30'd0, m_z[1], m_l[1]});
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (m_g[0]) begin
                m_rv[0] = 1'b1; m_y[0] = f_y(r0_a, r0_b, r0_ctr);
                m_z[0] = (m_y[0] == 32'd0); m_l[0] = f_less(r0_a, r0_b, r0_ctr);
            end else if (m_rv[0] && r0_rready) begin
                m_rv[0] = 1'b0;
            end
            if (m_g[1]) begin
                m_rv[1] = 1'b1; m_y[1] = f_y(r1_a, r1_b, r1_ctr);
                m_z[1] = (m_y[1] == 32'd0); m_l[1] = f_less(r1_a, r1_b, r1_ctr);
            end else if (m_rv[1] && r1_rready) begin
                m_rv[1] = 1'b0;
            end
            if (m_g[0]) m_last = 1'b0;
            else if (m_g[1]) m_last = 1'b1;
        end
        #1;
    endtask

    typedef struct {
        bit          v0, v1, rr0, rr1;
        logic [31:0] a0, b0, a1, b1;
        logic [3:0]  c0, c1;
        bit          g0, g1, rv0, rv1;
        logic [31:0] y0, y1;
    } vec_t;

    function automatic vec_t mk(input bit v0, input bit v1, input bit rr0, input bit rr1,
                                input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                                input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                                input bit g0, input bit g1, input bit rv0, input logic [31:0] y0,
                                input bit rv1, input logic [31:0] y1);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.rr0 = rr0; v.rr1 = rr1;
        v.a0 = a0; v.b0 = b0; v.c0 = c0; v.a1 = a1; v.b1 = b1; v.c1 = c1;
        v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.y0 = y0; v.rv1 = rv1; v.y1 = y1;
        return v;
    endfunction

    vec_t tbl[9];
    logic [3:0] ops[8];

    initial begin
        ops = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b1010, 4'b1011, 4'b0001, 4'b0100};
        // Sequence starts from reset: last_grant = 1, both slots empty.
`ifdef ALU_ARB_RR_EN
        tbl[0] = mk(1,1,1,1, 9,9,SUB, 1,2,ADD, 1,0, 1,0,  0,0);
        tbl[1] = mk(1,1,1,1, 9,9,SUB, 1,2,ADD, 0,1, 0,0,  1,3);
        tbl[2] = mk(1,1,1,1, 9,9,SUB, 1,2,ADD, 1,0, 1,0,  0,3);
        tbl[3] = mk(1,1,1,1, 9,9,SUB, 1,2,ADD, 0,1, 0,0,  1,3);
        tbl[4] = mk(1,0,1,1, 5,7,ADD, 0,0,ADD, 1,0, 1,12, 0,3);
`else
        tbl[0] = mk(1,1,1,1, 9,9,SUB, 1,2,ADD, 1,0, 1,0,  0,0);
        tbl[1] = mk(1,1,1,1, 9,9,SUB, 1,2,ADD, 1,0, 1,0,  0,0);
        tbl[2] = mk(1,1,1,1, 9,9,SUB, 1,2,ADD, 1,0, 1,0,  0,0);
        tbl[3] = mk(1,1,1,1, 9,9,SUB, 1,2,ADD, 1,0, 1,0,  0,0);
        tbl[4] = mk(1,0,1,1, 5,7,ADD, 0,0,ADD, 1,0, 1,12, 0,0);
`endif
        // Backpressure on r0, then rready raised: drain+refill in the same cycle.
        tbl[5] = mk(1,1,0,1, 1,1,ADD, 10,20,ADD, 0,1, 1,12, 1,30);
        tbl[6] = mk(1,1,0,1, 1,1,ADD, 4,4,ADD,   0,1, 1,12, 1,8);
        tbl[7] = mk(1,1,1,1, 1,1,ADD, 8,8,ADD,   1,0, 1,2,  0,8);
        tbl[8] = mk(0,0,1,1, 0,0,ADD, 0,0,ADD,   0,0, 0,2,  0,8);

        rst = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1; r0_rready = 1'b0; r1_rready = 1'b0;
        r0_a = 32'd3; r0_b = 32'd4; r0_ctr = ADD; r1_a = 32'd5; r1_b = 32'd6; r1_ctr = SUB;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cyc(1'b1);

        for (int i = 0; i < 9; i++) begin
            r0_valid = tbl[i].v0; r1_valid = tbl[i].v1;
            r0_rready = tbl[i].rr0; r1_rready = tbl[i].rr1;
            r0_a = tbl[i].a0; r0_b = tbl[i].b0; r0_ctr = tbl[i].c0;
            r1_a = tbl[i].a1; r1_b = tbl[i].b1; r1_ctr = tbl[i].c1;
            cyc(1'b0);
            chk($sformatf("vec%0d_g0", i), {31'd0, act_g[0]}, {31'd0, tbl[i].g0});
            chk($sformatf("vec%0d_g1", i), {31'd0, act_g[1]}, {31'd0, tbl[i].g1});
            chk($sformatf("vec%0d_rv0", i), {31'd0, r0_rvalid}, {31'd0, tbl[i].rv0});
            chk($sformatf("vec%0d_y0", i), r0_y, tbl[i].y0);
            chk($sformatf("vec%0d_rv1", i), {31'd0, r1_rvalid}, {31'd0, tbl[i].rv1});
            chk($sformatf("vec%0d_y1", i), r1_y, tbl[i].y1);
        end
        chk("single_add_zero", {31'd0, r0_zero}, 32'd0);

        // Reset mid-operation: grant r1, then reset while both request.
        r0_valid = 1'b0; r1_valid = 1'b1; r0_rready = 1'b0; r1_rready = 1'b0;
        r1_a = 32'd3; r1_b = 32'd4; r1_ctr = ADD;
        cyc(1'b0);
        chk("rstmid_grant_r1", {31'd0, act_g[1]}, 32'd1);
        r0_valid = 1'b1; r0_a = 32'd6; r0_b = 32'd1; r0_ctr = SUB;
        r1_a = 32'd2; r1_b = 32'd2; r1_ctr = ADD;
        cyc(1'b1);
        chk("rstmid_no_grant", {30'd0, act_g[0], act_g[1]}, 32'd0);
        chk("rstmid_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
        chk("rstmid_r1_y", r1_y, 32'd0);
        r0_rready = 1'b1; r1_rready = 1'b1;
        cyc(1'b0);
        chk("rstmid_first_r0", {30'd0, act_g[0], act_g[1]}, 32'd2);
        chk("rstmid_r0_y", r0_y, 32'd5);

        // Randomized traffic; a requester keeps its request stable until granted.
        for (int n = 0; n < 2000; n++) begin
            if (!r0_valid || m_g[0]) begin
                r0_valid = ($urandom_range(0, 3) != 0);
                r0_a = $urandom;
                r0_b = ($urandom_range(0, 3) == 0) ? r0_a : $urandom;
                r0_ctr = ops[$urandom_range(0, 7)];
            end
            if (!r1_valid || m_g[1]) begin
                r1_valid = ($urandom_range(0, 3) != 0);
                r1_a = $urandom;
                r1_b = ($urandom_range(0, 3) == 0) ? r1_a : $urandom;
                r1_ctr = ops[$urandom_range(0, 7)];
            end
            r0_rready = ($urandom_range(0, 9) < 7);
            r1_rready = ($urandom_range(0, 9) < 5);
            cyc($urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
